alu_serial: RTL and testbench

Parametrised multi-cycle ALU that computes AND, OR, ADD and SUB on WIDTH-bit operands, DIGIT bits per clock, using one DIGIT-wide slice and a carry flip-flop. It is the sequential, width-generic successor to the team's combinational 1-bit ALU slice. It sits between a host that issues start/operands and a consumer that samples a one-cycle valid strobe. Slice area scales with DIGIT rather than WIDTH; latency scales with WIDTH/DIGIT.

---
 rtl/alu_serial.sv | 119 +++++++++++
 tb/tb_alu_serial.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_serial.sv
// Digit-serial ALU: AND/OR/ADD/SUB on WIDTH-bit operands, DIGIT bits per clock,
// built from one DIGIT-wide slice plus a carry flip-flop.
module alu_serial #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       operation,
   output logic             ready,
   output logic             valid,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             overflow,
   output logic             zero
);

   localparam int N  = WIDTH / DIGIT;
   localparam int KW = $clog2(N + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   typedef enum logic [1:0] {OP_AND = 2'b00, OP_OR = 2'b01, OP_ADD = 2'b10, OP_SUB = 2'b11} op_t;

   state_t           state, state_nxt;
   op_t              op_q;
   logic [KW-1:0]    k;
   logic [WIDTH-1:0] a_sh, b_sh, acc, acc_nxt;
   logic             carry_q;

   logic             accept, last, arith;
   logic [DIGIT-1:0] a_d, b_d, slice;
   logic [DIGIT:0]   sum;
   logic             c_out, c_msb_in;

   assign ready  = (state != RUN);
   assign valid  = (state == DONE);
   assign accept = start & ready;
   assign last   = (k == KW'(N - 1));
   assign arith  = (op_q == OP_ADD) || (op_q == OP_SUB);

   // Slice: B is already inverted for SUB, so one adder serves both.
   assign a_d      = a_sh[DIGIT-1:0];
   assign b_d      = b_sh[DIGIT-1:0];
   assign sum      = {1'b0, a_d} + {1'b0, b_d} + (DIGIT+1)'(carry_q);
   assign c_out    = sum[DIGIT];
   assign c_msb_in = sum[DIGIT-1] ^ a_d[DIGIT-1] ^ b_d[DIGIT-1];

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      slice = sum[DIGIT-1:0];
      case (op_q)
         OP_AND:  slice = a_d & b_d;
         OP_OR:   slice = a_d | b_d;
         default: slice = sum[DIGIT-1:0];
      endcase
   end

   generate
      if (DIGIT == WIDTH) begin : g_full
         assign acc_nxt = slice;
      end else begin : g_shift
         assign acc_nxt = {slice, acc[WIDTH-1:DIGIT]};
      end
   endgenerate

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (last)  state_nxt = DONE;
         DONE:    state_nxt = start ? RUN : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         op_q      <= OP_AND;
         k         <= '0;
         a_sh      <= '0;
         b_sh      <= '0;
         acc       <= '0;
         carry_q   <= 1'b0;
         result    <= '0;
         carry_out <= 1'b0;
         overflow  <= 1'b0;
         zero      <= 1'b0;
      end else if (accept) begin
         op_q    <= op_t'(operation);
         k       <= '0;
         a_sh    <= a;
         b_sh    <= (op_t'(operation) == OP_SUB) ? ~b : b;
         acc     <= '0;
         carry_q <= (op_t'(operation) == OP_SUB);
      end else if (state == RUN) begin
         a_sh <= a_sh >> DIGIT;
         b_sh <= b_sh >> DIGIT;
         acc  <= acc_nxt;
         k    <= k + KW'(1);
         if (arith) carry_q <= c_out;
         if (last) begin
            result    <= acc_nxt;
            carry_out <= arith & c_out;
            overflow  <= arith & (c_out ^ c_msb_in);
            zero      <= (acc_nxt == '0);
         end
      end
   end

endmodule

// File: tb/tb_alu_serial.sv
// Self-checking bench for alu_serial: scoreboard of expected results, directed steps,
// an 8/1 instance for the main plan and an 8/4 instance for the digit-width variant.
module tb_alu_serial;

   logic       clk = 1'b0;
   logic       rst, start, start4;
   logic [7:0] a, b, a4, b4;
   logic [1:0] operation, op4;
   logic       ready, valid, carry_out, overflow, zero;
   logic       ready4, valid4, carry_out4, overflow4, zero4;
   logic [7:0] result, result4;

   always #5 clk = ~clk;

   alu_serial #(.WIDTH(8), .DIGIT(1)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .operation(operation),
      .ready(ready), .valid(valid), .result(result), .carry_out(carry_out),
      .overflow(overflow), .zero(zero)
   );

   alu_serial #(.WIDTH(8), .DIGIT(4)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .operation(op4),
      .ready(ready4), .valid(valid4), .result(result4), .carry_out(carry_out4),
      .overflow(overflow4), .zero(zero4)
   );

   typedef struct packed {
      logic [7:0] res;
      logic       c;
      logic       v;
      logic       z;
   } exp_t;

   exp_t sb[$];
   exp_t sb4[$];
   int   tests = 0;
   int   fails = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   function automatic exp_t model(input logic [7:0] x, input logic [7:0] y, input logic [1:0] op);
      exp_t       e;
      logic [8:0] s;
      e = '0;
      case (op)
         2'b00: e.res = x & y;
         2'b01: e.res = x | y;
         2'b10: begin
            s     = {1'b0, x} + {1'b0, y};
            e.res = s[7:0];
            e.c   = s[8];
            e.v   = (x[7] == y[7]) && (e.res[7] != x[7]);
         end
         default: begin
            e.res = x - y;
            e.c   = (x >= y);
            e.v   = (x[7] != y[7]) && (e.res[7] != x[7]);
         end
      endcase
      e.z = (e.res == 8'h00);
      return e;
   endfunction

   // Caller must be at a falling edge; start is presented for the following rising edge.
   task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic [1:0] iop);
      a         = ia;
      b         = ib;
      operation = iop;
      start     = 1'b1;
      sb.push_back(model(ia, ib, iop));
   endtask

   task automatic await_result(input string tag, input bit disturb);
      exp_t e;
      bit   seen;
      seen = 1'b0;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         start = 1'b0;
         if (disturb && n >= 2 && n <= 6) begin
            a         = 8'($urandom);
            b         = 8'($urandom);
            operation = 2'($urandom);
            start     = (n == 3 || n == 5);
         end
         if (valid) begin
            seen = 1'b1;
            check({tag, " latency"}, n, 9);
            check({tag, " sb nonempty"}, (sb.size() != 0), 1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               check({tag, " result"}, result, e.res);
               check({tag, " carry_out"}, carry_out, e.c);
               check({tag, " overflow"}, overflow, e.v);
               check({tag, " zero"}, zero, e.z);
               check({tag, " ready in done"}, ready, 1);
            end
            break;
         end else if (n <= 8) begin
            check({tag, " ready low in run"}, ready, 0);
         end
      end
      check({tag, " valid seen"}, seen, 1);
   endtask

   task automatic idle_after(input string tag);
      @(negedge clk);
      check({tag, " valid drops"}, valid, 0);
      check({tag, " ready idle"}, ready, 1);
   endtask

   task automatic quiet(input string tag, input int cycles);
      int pulses;
      pulses = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (valid) pulses++;
      end
      check({tag, " no extra valid"}, pulses, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      bit   seen;

      rst       = 1'b1;
      start     = 1'b1;
      a         = 8'hFF;
      b         = 8'h01;
      operation = 2'b10;
      start4    = 1'b0;
      a4        = 8'h00;
      b4        = 8'h00;
      op4       = 2'b00;

      // Reset held two cycles with start asserted.
      repeat (2) @(negedge clk);
      check("rst ready", ready, 1);
      check("rst valid", valid, 0);
      check("rst result", result, 8'h00);
      check("rst carry_out", carry_out, 0);
      check("rst overflow", overflow, 0);
      check("rst zero", zero, 0);
      check("rst ready4", ready4, 1);
      rst   = 1'b0;
      start = 1'b0;
      @(negedge clk);
      check("post rst ready", ready, 1);
      check("post rst valid", valid, 0);

      issue(8'hF0, 8'h20, 2'b10); await_result("add_f0_20", 0); idle_after("add_f0_20");
      issue(8'h7F, 8'h01, 2'b10); await_result("add_7f_01", 0); idle_after("add_7f_01");
      issue(8'h05, 8'h05, 2'b11); await_result("sub_05_05", 0); idle_after("sub_05_05");
      issue(8'h03, 8'h05, 2'b11); await_result("sub_03_05", 0); idle_after("sub_03_05");
      issue(8'h80, 8'h01, 2'b11); await_result("sub_80_01", 0); idle_after("sub_80_01");
      issue(8'hA5, 8'h3C, 2'b00); await_result("and_a5_3c", 0); idle_after("and_a5_3c");
      issue(8'hA5, 8'h3C, 2'b01); await_result("or_a5_3c", 0);  idle_after("or_a5_3c");

      // Inputs churn and start pulses during RUN must not disturb the operation.
      issue(8'h12, 8'h34, 2'b10); await_result("disturb", 1); quiet("disturb", 12);

      // Back-to-back: start re-asserted in the DONE cycle.
      issue(8'hF0, 8'h20, 2'b10); await_result("b2b first", 0);
      issue(8'h80, 8'h01, 2'b11); await_result("b2b second", 0);
      idle_after("b2b");

      // Abort: reset asserted in RUN cycle 4 (fresh reset so result starts at 0).
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      issue(8'hF0, 8'h20, 2'b10);
      repeat (4) begin
         @(negedge clk);
         start = 1'b0;
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      void'(sb.pop_back());
      check("abort ready", ready, 1);
      check("abort valid", valid, 0);
      check("abort result", result, 8'h00);
      check("abort zero", zero, 0);
      quiet("abort", 12);
      check("abort result held", result, 8'h00);

      // DIGIT=4 instance: N=2, valid expected three cycles after the start cycle.
      a4     = 8'hF0;
      b4     = 8'h20;
      op4    = 2'b10;
      start4 = 1'b1;
      sb4.push_back(model(8'hF0, 8'h20, 2'b10));
      seen = 1'b0;
      for (int n = 1; n <= 10; n++) begin
         @(negedge clk);
         start4 = 1'b0;
         if (valid4) begin
            seen = 1'b1;
            check("d4 latency", n, 3);
            e = sb4.pop_front();
            check("d4 result", result4, e.res);
            check("d4 carry_out", carry_out4, e.c);
            check("d4 overflow", overflow4, e.v);
            check("d4 zero", zero4, e.z);
            break;
         end
      end
      check("d4 valid seen", seen, 1);

      check("scoreboard drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
